// File: rtl/multicycle_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu_pkg
// Brief    : Opcode and FSM state encodings shared by the multicycle ALU.
// Revision : 1.0
// ============================================================================
package multicycle_alu_pkg;

    localparam int C_OPW = 5;

    localparam logic [C_OPW-1:0] C_OP_ADD    = 5'd0;
    localparam logic [C_OPW-1:0] C_OP_SUB    = 5'd1;
    localparam logic [C_OPW-1:0] C_OP_SLL    = 5'd2;
    localparam logic [C_OPW-1:0] C_OP_SRL    = 5'd3;
    localparam logic [C_OPW-1:0] C_OP_SRA    = 5'd4;
    localparam logic [C_OPW-1:0] C_OP_XOR    = 5'd5;
    localparam logic [C_OPW-1:0] C_OP_OR     = 5'd6;
    localparam logic [C_OPW-1:0] C_OP_AND    = 5'd7;
    localparam logic [C_OPW-1:0] C_OP_SLT    = 5'd8;
    localparam logic [C_OPW-1:0] C_OP_SLTU   = 5'd9;
    localparam logic [C_OPW-1:0] C_OP_BEQ    = 5'd10;
    localparam logic [C_OPW-1:0] C_OP_BNE    = 5'd11;
    localparam logic [C_OPW-1:0] C_OP_BLT    = 5'd12;
    localparam logic [C_OPW-1:0] C_OP_BGE    = 5'd13;
    localparam logic [C_OPW-1:0] C_OP_BLTU   = 5'd14;
    localparam logic [C_OPW-1:0] C_OP_BGEU   = 5'd15;
    localparam logic [C_OPW-1:0] C_OP_ZERO   = 5'd16;
    // Iterative operations occupy the codes above the original ALU set.
    localparam logic [C_OPW-1:0] C_OP_MUL    = 5'd17;
    localparam logic [C_OPW-1:0] C_OP_MULH   = 5'd18;
    localparam logic [C_OPW-1:0] C_OP_MULHSU = 5'd19;
    localparam logic [C_OPW-1:0] C_OP_MULHU  = 5'd20;
    localparam logic [C_OPW-1:0] C_OP_DIV    = 5'd21;
    localparam logic [C_OPW-1:0] C_OP_DIVU   = 5'd22;
    localparam logic [C_OPW-1:0] C_OP_REM    = 5'd23;
    localparam logic [C_OPW-1:0] C_OP_REMU   = 5'd24;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_MUL  = 2'd1;
    localparam logic [1:0] C_ST_DIV  = 2'd2;
    localparam logic [1:0] C_ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv
// Brief    : Bit-serial shift-add multiplier / restoring divider on operand
//            magnitudes, with sign fix-up applied to the final iteration.
// Revision : 1.0
// ============================================================================
module iter_muldiv
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [OPW-1:0]  i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

    logic            r_busy;
    logic            r_is_div;
    logic            r_hi_sel;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;

    logic              w_op_mulh, w_op_mulhsu, w_op_mulhu;
    logic              w_op_div, w_op_divu, w_op_rem, w_op_remu;
    logic              w_is_div, w_hi_sel, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic              w_div_fit;
    logic [XLEN-1:0]   w_nx_hi, w_nx_lo, w_quo, w_rem;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    assign w_op_mulh   = (i_op == OPW'(C_OP_MULH));
    assign w_op_mulhsu = (i_op == OPW'(C_OP_MULHSU));
    assign w_op_mulhu  = (i_op == OPW'(C_OP_MULHU));
    assign w_op_div    = (i_op == OPW'(C_OP_DIV));
    assign w_op_divu   = (i_op == OPW'(C_OP_DIVU));
    assign w_op_rem    = (i_op == OPW'(C_OP_REM));
    assign w_op_remu   = (i_op == OPW'(C_OP_REMU));

    assign w_is_div = w_op_div | w_op_divu | w_op_rem | w_op_remu;
    assign w_hi_sel = w_op_mulh | w_op_mulhsu | w_op_mulhu | w_op_rem | w_op_remu;
    assign w_a_neg  = (w_op_mulh | w_op_mulhsu | w_op_div | w_op_rem) & i_a[XLEN-1];
    assign w_b_neg  = (w_op_mulh | w_op_div | w_op_rem) & i_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // hi:lo is the product (mul) or remainder:dividend/quotient (div).
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_div_fit   = ~w_div_diff[XLEN];

    always_comb begin
        if (r_is_div) begin
            w_nx_hi = w_div_fit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_nx_lo = {r_lo[XLEN-2:0], w_div_fit};
        end else begin
            w_nx_hi = w_mul_sum[XLEN:1];
            w_nx_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Result is taken from the step in flight so it is ready on the last edge.
    assign w_prod     = {w_nx_hi, w_nx_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -w_nx_lo : w_nx_lo;
    assign w_rem      = r_neg_r ? -w_nx_hi : w_nx_hi;
    assign o_result   = r_is_div ? (r_hi_sel ? w_rem : w_quo)
                                 : (r_hi_sel ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);
    assign o_done     = r_busy && (r_count == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_hi_sel <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= w_is_div;
            r_hi_sel <= w_hi_sel;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
            r_opd    <= w_is_div ? w_b_mag : w_a_mag;
        end else if (r_busy) begin
            r_hi    <= w_nx_hi;
            r_lo    <= w_nx_lo;
            r_count <= r_count + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Valid/ready ALU with single-cycle ops and iterative mul/div.
// Revision : 1.0
// ============================================================================
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_bcond
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_result;
    logic            r_bcond;

    logic [SHW-1:0]  w_shamt;
    logic            w_lt, w_ltu, w_eq;
    logic            w_is_mul, w_is_div, w_div_signed, w_want_rem;
    logic            w_div_zero, w_div_ovf, w_early;
    logic [XLEN-1:0] w_early_result, w_imm_result;
    logic            w_imm_bcond;
    logic            w_start, w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_shamt = alu_in_2[SHW-1:0];
    assign w_lt    = $signed(alu_in_1) < $signed(alu_in_2);
    assign w_ltu   = alu_in_1 < alu_in_2;
    assign w_eq    = alu_in_1 == alu_in_2;

    assign w_is_mul = (alu_op == OPW'(C_OP_MUL))    || (alu_op == OPW'(C_OP_MULH)) ||
                      (alu_op == OPW'(C_OP_MULHSU)) || (alu_op == OPW'(C_OP_MULHU));
    assign w_div_signed = (alu_op == OPW'(C_OP_DIV)) || (alu_op == OPW'(C_OP_REM));
    assign w_want_rem   = (alu_op == OPW'(C_OP_REM)) || (alu_op == OPW'(C_OP_REMU));
    assign w_is_div     = w_div_signed || w_want_rem || (alu_op == OPW'(C_OP_DIVU));

    // Divide-by-zero and MIN/-1 bypass the iterative datapath entirely.
    assign w_div_zero     = (alu_in_2 == '0);
    assign w_div_ovf      = w_div_signed && (alu_in_1 == C_MIN) && (alu_in_2 == '1);
    assign w_early        = w_is_div && (w_div_zero || w_div_ovf);
    assign w_early_result = w_div_zero ? (w_want_rem ? alu_in_1 : '1)
                                       : (w_want_rem ? '0 : C_MIN);

    always_comb begin
        w_imm_result = '0;
        w_imm_bcond  = 1'b0;
        case (alu_op)
            OPW'(C_OP_ADD):  w_imm_result = alu_in_1 + alu_in_2;
            OPW'(C_OP_SUB):  w_imm_result = alu_in_1 - alu_in_2;
            OPW'(C_OP_SLL):  w_imm_result = alu_in_1 << w_shamt;
            OPW'(C_OP_SRL):  w_imm_result = alu_in_1 >> w_shamt;
            OPW'(C_OP_SRA):  w_imm_result = XLEN'($signed(alu_in_1) >>> w_shamt);
            OPW'(C_OP_XOR):  w_imm_result = alu_in_1 ^ alu_in_2;
            OPW'(C_OP_OR):   w_imm_result = alu_in_1 | alu_in_2;
            OPW'(C_OP_AND):  w_imm_result = alu_in_1 & alu_in_2;
            OPW'(C_OP_SLT):  w_imm_result = XLEN'(w_lt);
            OPW'(C_OP_SLTU): w_imm_result = XLEN'(w_ltu);
            OPW'(C_OP_BEQ):  w_imm_bcond  = w_eq;
            OPW'(C_OP_BNE):  w_imm_bcond  = !w_eq;
            OPW'(C_OP_BLT):  w_imm_bcond  = w_lt;
            OPW'(C_OP_BGE):  w_imm_bcond  = !w_lt;
            OPW'(C_OP_BLTU): w_imm_bcond  = w_ltu;
            OPW'(C_OP_BGEU): w_imm_bcond  = !w_ltu;
            default: ;
        endcase
        if (w_early) begin
            w_imm_result = w_early_result;
        end
    end

    assign w_start = (r_state == C_ST_IDLE) && in_valid && (w_is_mul || (w_is_div && !w_early));

    iter_muldiv #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) u_iter_muldiv (
        .clk      (clk),
        .rst      (reset),
        .i_start  (w_start),
        .i_op     (alu_op),
        .i_a      (alu_in_1),
        .i_b      (alu_in_2),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_ST_IDLE;
            r_result <= '0;
            r_bcond  <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            r_state <= C_ST_MUL;
                        end else if (w_is_div && !w_early) begin
                            r_state <= C_ST_DIV;
                        end else begin
                            r_state  <= C_ST_DONE;
                            r_result <= w_imm_result;
                            r_bcond  <= w_imm_bcond;
                        end
                    end
                end
                C_ST_MUL, C_ST_DIV: begin
                    if (w_md_done) begin
                        r_state  <= C_ST_DONE;
                        r_result <= w_md_result;
                        r_bcond  <= 1'b0;
                    end
                end
                C_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == C_ST_IDLE);
    assign out_valid  = (r_state == C_ST_DONE);
    assign alu_result = r_result;
    assign alu_bcond  = r_bcond;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Self-checking bench: directed vectors, corner sequences and
//            random operations against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    localparam int XLEN = 32;
    localparam int MD_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] alu_in_1, alu_in_2;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] alu_result;
    logic            alu_bcond;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    multicycle_alu #(.XLEN(XLEN), .OPW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written directly from the RV32M-style operation rules.
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic bc, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b & 32'd31);
        r = '0; bc = 1'b0; lat = 1; p = '0;
        case (op)
            C_OP_ADD:    r = a + b;
            C_OP_SUB:    r = a - b;
            C_OP_SLL:    r = a << sh;
            C_OP_SRL:    r = a >> sh;
            C_OP_SRA:    r = 32'(sa >>> sh);
            C_OP_XOR:    r = a ^ b;
            C_OP_OR:     r = a | b;
            C_OP_AND:    r = a & b;
            C_OP_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
            C_OP_SLTU:   r = (ua < ub) ? 32'd1 : 32'd0;
            C_OP_BEQ:    bc = (a == b);
            C_OP_BNE:    bc = (a != b);
            C_OP_BLT:    bc = (sa < sb);
            C_OP_BGE:    bc = (sa >= sb);
            C_OP_BLTU:   bc = (ua < ub);
            C_OP_BGEU:   bc = (ua >= ub);
            C_OP_MUL:    begin p = ua * ub; r = p[31:0];  lat = MD_LAT; end
            C_OP_MULH:   begin p = sa * sb; r = p[63:32]; lat = MD_LAT; end
            C_OP_MULHSU: begin p = sa * ub; r = p[63:32]; lat = MD_LAT; end
            C_OP_MULHU:  begin p = ua * ub; r = p[63:32]; lat = MD_LAT; end
            C_OP_DIV, C_OP_DIVU, C_OP_REM, C_OP_REMU: begin
                if (b == 32'd0) begin
                    r = (op == C_OP_REM || op == C_OP_REMU) ? a : 32'hFFFF_FFFF;
                end else if ((op == C_OP_DIV || op == C_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (op == C_OP_DIV) ? 32'h8000_0000 : 32'd0;
                end else begin
                    lat = MD_LAT;
                    case (op)
                        C_OP_DIV:  r = 32'(sa / sb);
                        C_OP_REM:  r = 32'(sa % sb);
                        C_OP_DIVU: r = 32'(ua / ub);
                        default:   r = 32'(ua % ub);
                    endcase
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one operation, measure cycles to out_valid, then take the result.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic bc, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_op = op; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = 0;
        res = alu_result;
        bc  = alu_bcond;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res, exp_res;
        logic        bc, exp_bc;
        int          lat, exp_lat, seen;
        logic [31:0] sp[6];

        vecs[0]  = '{C_OP_ADD,    32'd5,          32'd7,          32'd12,          1'b0, 1};
        vecs[1]  = '{C_OP_BLTU,   32'd1,          32'hFFFF_FFFF,  32'd0,           1'b1, 1};
        vecs[2]  = '{C_OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,   1'b0, 33};
        vecs[3]  = '{C_OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,           1'b0, 33};
        vecs[4]  = '{C_OP_DIVU,   32'h1234,       32'd0,          32'hFFFF_FFFF,   1'b0, 1};
        vecs[5]  = '{C_OP_REM,    32'd9,          32'd0,          32'd9,           1'b0, 1};
        vecs[6]  = '{C_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1'b0, 1};
        vecs[7]  = '{C_OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,           1'b0, 33};
        vecs[8]  = '{C_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   1'b0, 33};
        vecs[9]  = '{C_OP_SRA,    32'h8000_0000,  32'h21,         32'hC000_0000,   1'b0, 1};
        vecs[10] = '{C_OP_SLL,    32'd1,          32'h3F,         32'h8000_0000,   1'b0, 1};
        vecs[11] = '{5'd31,       32'd5,          32'd7,          32'd0,           1'b0, 1};
        vecs[12] = '{C_OP_MUL,    32'd12345,      32'd100,        32'd1234500,     1'b0, 33};
        vecs[13] = '{C_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,   1'b0, 33};
        vecs[14] = '{C_OP_REMU,   32'd100,        32'd7,          32'd2,           1'b0, 33};
        vecs[15] = '{C_OP_BLT,    32'h8000_0000,  32'd1,          32'd0,           1'b1, 1};
        vecs[16] = '{C_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1'b0, 1};
        vecs[17] = '{C_OP_SLT,    32'hFFFF_FFFF,  32'd0,          32'd1,           1'b0, 1};
        vecs[18] = '{C_OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   1'b0, 33};
        vecs[19] = '{C_OP_SRL,    32'h8000_0000,  32'h1F,         32'd1,           1'b0, 1};

        sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF; sp[5] = 32'd2;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; alu_in_1 = '0; alu_in_2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", alu_result, 0);
        check("reset bcond", alu_bcond, 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, bc, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].res);
            check($sformatf("vec%0d bcond", i), bc, vecs[i].bc);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        // Result held in DONE while the consumer stalls; new requests ignored.
        @(negedge clk);
        alu_op = C_OP_BGE; alu_in_1 = 32'd5; alu_in_2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            alu_op = C_OP_ADD; alu_in_1 = 32'd100; alu_in_2 = 32'd23; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("hold%0d result", k), alu_result, 0);
            check($sformatf("hold%0d bcond", k), alu_bcond, 1);
            check($sformatf("hold%0d in_ready", k), in_ready, 0);
            check($sformatf("hold%0d out_valid", k), out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold no extra out_valid", out_valid, 0);
        check("hold in_ready after", in_ready, 1);

        // Reset aborts a divide at iteration 10.
        do_op(C_OP_ADD, 32'd40, 32'd2, res, bc, lat);
        check("pre-abort result", res, 42);
        @(negedge clk);
        alu_op = C_OP_DIV; alu_in_1 = 32'd1000; alu_in_2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort result", alu_result, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no output", seen, 0);

        // Reset wins over an accept in the same cycle.
        @(negedge clk);
        reset = 1'b1; alu_op = C_OP_ADD; alu_in_1 = 32'd1; alu_in_2 = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst-prio in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("rst-prio out_valid", out_valid, 0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom();
            b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom();
            ref_model(op, a, b, exp_res, exp_bc, exp_lat);
            do_op(op, a, b, res, bc, lat);
            check($sformatf("rnd%0d op%0d result", n, op), res, exp_res);
            check($sformatf("rnd%0d op%0d bcond", n, op), bc, exp_bc);
            check($sformatf("rnd%0d op%0d latency", n, op), lat, exp_lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (any even value ≥ 8).
REQ-002 SHALL have parameter OPW, default 5, giving the width of alu_op.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port alu_op, input, OPW: operation code, sampled on accept.
REQ-006 SHALL have port alu_in_1, input, XLEN: operand A, sampled on accept.
REQ-007 SHALL have port alu_in_2, input, XLEN: operand B, sampled on accept.
REQ-008 SHALL have port in_valid, input, 1: operands and alu_op are valid.
REQ-009 SHALL have port in_ready, output, 1: the unit can accept an operation.
REQ-010 SHALL have port out_valid, output, 1: alu_result and alu_bcond are valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-012 SHALL have port alu_result, output, XLEN: registered result.
REQ-013 SHALL have port alu_bcond, output, 1: registered branch condition.

Function
REQ-014 SHALL accept an operation on a clock edge where in_valid && in_ready.
REQ-015 SHALL deliver a result on a clock edge where out_valid && out_ready.
REQ-016 SHALL use states IDLE, MUL, DIV and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-017 SHALL support single-cycle ops ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU and ZERO.
REQ-018 SHALL, for a single-cycle op, go IDLE→DONE on accept, so out_valid rises on the first cycle after accept.
REQ-019 SHALL use only the low $clog2(XLEN) bits of alu_in_2 as the shift amount, and SRA SHALL sign-fill.
REQ-020 SHALL, for branch ops, set alu_result = 0 and drive alu_bcond from the compare; for all other ops alu_bcond = 0.
REQ-021 SHALL support iterative ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, computed with RV32M semantics generalised to XLEN.
REQ-022 SHALL, for MUL*, go IDLE→MUL and perform XLEN shift-add iterations (one per cycle, 2·XLEN-bit product), then MUL→DONE.
REQ-023 SHALL, for DIV*/REM*, go IDLE→DIV and perform XLEN restoring iterations on magnitudes, apply sign correction on exit, then DIV→DONE.
REQ-024 SHALL make out_valid rise exactly XLEN+1 cycles after the accepting edge for MUL/DIV-class ops.
REQ-025 SHALL treat divide by zero as an early-out: go IDLE→DONE, quotient = all ones, remainder = alu_in_1.
REQ-026 SHALL treat signed overflow (MIN / −1) as an early-out: go IDLE→DONE, quotient = MIN, remainder = 0.
REQ-027 SHALL hold alu_result and alu_bcond stable in DONE while out_ready = 0.
REQ-028 SHALL go DONE→IDLE on delivery; an accept is not possible in that same cycle, so the minimum issue interval is 2 cycles.
REQ-029 SHALL treat an unknown alu_op as ZERO: result 0, bcond 0, latency 1.
REQ-030 SHALL ignore in_valid whenever the unit is not in IDLE, and SHALL not consume any input.

Reset
REQ-031 SHALL, with reset high at an edge, set state = IDLE, alu_result = 0, alu_bcond = 0, iteration counter = 0, out_valid = 0 and in_ready = 1.
REQ-032 SHALL let reset abort any MUL/DIV in progress or pending result, producing no output afterwards.
REQ-033 SHALL give reset priority over accept in the same cycle.

Structure
REQ-034 SHALL define opcode constants (OPW wide) and the state encoding in the shared alu_opcodes header/package, extending the existing ALU codes.
REQ-035 SHALL place the iterative multiply/divide datapath (operand and product registers, counter, sign fix-up) in one sub-module, iter_muldiv, with start/done signalling.

Verification (XLEN=32)
REQ-036 SHALL check ADD 5+7 → 12 with out_valid one cycle after accept, and BLTU 1 vs 0xFFFFFFFF → bcond=1, result=0.
REQ-037 SHALL check DIV 7/−2 → 0xFFFFFFFD and REM 7/−2 → 1, each with out_valid at accept+33.
REQ-038 SHALL check DIVU x/0 → 0xFFFFFFFF, REM 9/0 → 9 and DIV 0x80000000/−1 → 0x80000000, each with latency 1.
REQ-039 SHALL check MULH 0xFFFFFFFF*0xFFFFFFFF → 0 and MULHU of the same operands → 0xFFFFFFFE.
REQ-040 SHALL check that with out_ready held low for 3 cycles in DONE, result and bcond stay stable, in_ready stays 0 and in_valid pulses are ignored.
REQ-041 SHALL check that reset asserted at iteration 10 of a DIV gives in_ready=1 next cycle, with no out_valid afterwards.
